// File: rtl/alu_isa_pkg.sv
// alu_isa_pkg
//   Shared definitions for the 4-bit decode/execute datapath: opcode encodings,
//   instruction word layout ({sel,rs,rt}) and the issue FSM state encoding.
package alu_isa_pkg;

  localparam int SEL_W   = 3;
  localparam int REG_W   = 4;
  localparam int INSTR_W = SEL_W + 2 * REG_W;  // 11

  localparam logic [SEL_W-1:0] OP_SUB = 3'd0;
  localparam logic [SEL_W-1:0] OP_ADD = 3'd1;
  localparam logic [SEL_W-1:0] OP_OR  = 3'd2;
  localparam logic [SEL_W-1:0] OP_AND = 3'd3;
  localparam logic [SEL_W-1:0] OP_RSH = 3'd4;
  localparam logic [SEL_W-1:0] OP_LSH = 3'd5;
  localparam logic [SEL_W-1:0] OP_LT  = 3'd6;
  localparam logic [SEL_W-1:0] OP_EQ  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } issue_state_e;

  function automatic logic [INSTR_W-1:0] pack_instr(
    input logic [SEL_W-1:0] sel,
    input logic [REG_W-1:0] rs,
    input logic [REG_W-1:0] rt
  );
    return {sel, rs, rt};
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// instr_fifo
//   DEPTH x INSTR_W circular instruction queue with first-word fall-through
//   read data. DEPTH must be a power of 2 so pointers wrap naturally.
// Ports
//   clk, rst   : clock, synchronous active-high reset (empties the queue)
//   push_i     : write wdata_i at tail (caller guarantees !full_o)
//   pop_i      : advance head (caller guarantees !empty_o)
//   wdata_i    : instruction word to enqueue
//   rdata_o    : instruction word at head
//   full_o     : DEPTH entries held
//   empty_o    : no entries held
module instr_fifo
  import alu_isa_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [INSTR_W-1:0] wdata_i,
  output logic [INSTR_W-1:0] rdata_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     count_q, count_d;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  // Simultaneous push and pop leave the occupancy unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Storage is data only; it needs no reset.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/instr_issue_ctrl.sv
// instr_issue_ctrl
//   Issue side of the 4-bit decode/execute datapath. Queues {sel,rs,rt}
//   instruction words from the host, presents them one at a time to the
//   combinational executor over valid/ready, captures the returned rd and
//   counts completed issues.
//   Optional feature macro: INSTR_STEP_EN -- when defined, leaving IDLE also
//   needs a step pulse, so one instruction issues per pulse. When undefined,
//   step is ignored and issue is free-running.
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : host push handshake (in_ready = queue not full)
//   in_sel/in_rs/in_rt  : instruction fields offered by the host
//   iss_valid/iss_ready : executor handshake
//   iss_sel/iss_rs/iss_rt : registered instruction to executor
//   res_rd              : executor result, combinational from iss_*
//   res_valid           : one-cycle pulse when last_rd is updated
//   last_rd             : most recently captured result
//   issued_cnt          : completed issues, wraps silently
//   step                : single-step pulse (INSTR_STEP_EN only)
module instr_issue_ctrl
  import alu_isa_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_sel,
  input  logic [3:0]       in_rs,
  input  logic [3:0]       in_rt,
  output logic             iss_valid,
  input  logic             iss_ready,
  output logic [2:0]       iss_sel,
  output logic [3:0]       iss_rs,
  output logic [3:0]       iss_rt,
  input  logic [3:0]       res_rd,
  output logic             res_valid,
  output logic [3:0]       last_rd,
  output logic [CNT_W-1:0] issued_cnt,
  input  logic             step
);

  issue_state_e       state_q;
  logic [INSTR_W-1:0] head_instr;
  logic               fifo_full, fifo_empty;
  logic               push, pop, go;

  logic               iss_valid_q, res_valid_q;
  logic [SEL_W-1:0]   iss_sel_q;
  logic [REG_W-1:0]   iss_rs_q, iss_rt_q, last_rd_q;
  logic [CNT_W-1:0]   issued_cnt_q;

  // in_ready looks only at full, never at a same-cycle pop, so it stays a
  // pure register decode with no path back through the FSM.
  assign in_ready = !fifo_full;
  assign push     = in_valid && !fifo_full;
  assign pop      = (state_q == ST_LOAD);

`ifdef INSTR_STEP_EN
  assign go = !fifo_empty && step;
`else
  logic unused_step;
  assign unused_step = step;
  assign go = !fifo_empty;
`endif

  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (pack_instr(in_sel, in_rs, in_rt)),
    .rdata_o (head_instr),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Reset drops any in-flight issue without counting it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      iss_valid_q  <= 1'b0;
      iss_sel_q    <= '0;
      iss_rs_q     <= '0;
      iss_rt_q     <= '0;
      res_valid_q  <= 1'b0;
      last_rd_q    <= '0;
      issued_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (go) state_q <= ST_LOAD;
        end
        // The only state where iss_* change.
        ST_LOAD: begin
          {iss_sel_q, iss_rs_q, iss_rt_q} <= head_instr;
          iss_valid_q <= 1'b1;
          state_q     <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (iss_ready) begin
            last_rd_q    <= res_rd;
            res_valid_q  <= 1'b1;
            issued_cnt_q <= issued_cnt_q + CNT_W'(1);
            iss_valid_q  <= 1'b0;
            state_q      <= ST_DONE;
          end
        end
        ST_DONE: begin
          res_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign iss_valid  = iss_valid_q;
  assign iss_sel    = iss_sel_q;
  assign iss_rs     = iss_rs_q;
  assign iss_rt     = iss_rt_q;
  assign res_valid  = res_valid_q;
  assign last_rd    = last_rd_q;
  assign issued_cnt = issued_cnt_q;

endmodule

// File: tb/tb_instr_issue_ctrl.sv
module tb_instr_issue_ctrl;
  import alu_isa_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_sel = '0;
  logic [3:0]       in_rs = '0, in_rt = '0;
  logic             iss_valid;
  logic             iss_ready = 1'b0;
  logic [2:0]       iss_sel;
  logic [3:0]       iss_rs, iss_rt;
  logic [3:0]       res_rd;
  logic             res_valid;
  logic [3:0]       last_rd;
  logic [CNT_W-1:0] issued_cnt;
  logic             step = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [INSTR_W-1:0] exp_q [$];
  int model_cnt = 0;

  always #5 clk = ~clk;

  // Golden executor.
  function automatic logic [3:0] alu(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
    case (s)
      OP_SUB:  return a - b;
      OP_ADD:  return a + b;
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      OP_RSH:  return a >> b[1:0];
      OP_LSH:  return a << b[1:0];
      OP_LT:   return {3'b000, (a < b)};
      default: return {3'b000, (a == b)};
    endcase
  endfunction

  assign res_rd = alu(iss_sel, iss_rs, iss_rt);

  instr_issue_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .iss_valid  (iss_valid),
    .iss_ready  (iss_ready),
    .iss_sel    (iss_sel),
    .iss_rs     (iss_rs),
    .iss_rt     (iss_rt),
    .res_rd     (res_rd),
    .res_valid  (res_valid),
    .last_rd    (last_rd),
    .issued_cnt (issued_cnt),
    .step       (step)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: records handshakes seen before the edge, then scores the
  // outputs #1 after it.
  task automatic tick();
    logic pushed, issued, rst_s;
    logic [INSTR_W-1:0] pw, iw, e;
    pushed = in_valid && in_ready;
    issued = iss_valid && iss_ready;
    rst_s  = rst;
    pw     = {in_sel, in_rs, in_rt};
    iw     = {iss_sel, iss_rs, iss_rt};
    @(posedge clk);
    #1;
    if (rst_s) begin
      exp_q.delete();
      model_cnt = 0;
      check("rst_iss_valid", 32'(iss_valid), 0);
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_issued_cnt", 32'(issued_cnt), 0);
      check("rst_last_rd", 32'(last_rd), 0);
      check("rst_res_valid", 32'(res_valid), 0);
    end else begin
      if (issued) begin
        check("sb_nonempty", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          model_cnt++;
          check("issue_word", 32'(iw), 32'(e));
          check("res_valid_pulse", 32'(res_valid), 1);
          check("last_rd", 32'(last_rd), 32'(alu(e[10:8], e[7:4], e[3:0])));
          check("issued_cnt", 32'(issued_cnt), 32'(model_cnt[CNT_W-1:0]));
        end
      end else begin
        check("res_valid_quiet", 32'(res_valid), 0);
      end
      if (pushed) exp_q.push_back(pw);
    end
  endtask

  task automatic push(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
    int n;
    in_valid = 1'b1; in_sel = s; in_rs = a; in_rt = b;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    check("push_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_iss_valid();
    int n;
    n = 0;
    while (!iss_valid && n < 20) begin tick(); n++; end
    check("wait_iss_valid", 32'(iss_valid), 1);
  endtask

  task automatic drain();
    int n;
    iss_ready = 1'b1;
    n = 0;
    while ((exp_q.size() > 0 || iss_valid || res_valid) && n < 200) begin tick(); n++; end
    check("drain_empty", 32'(exp_q.size()), 0);
    tick();
  endtask

  initial begin
    int n, npush, cnt0;
    logic step_hold;
`ifdef INSTR_STEP_EN
    step_hold = 1'b1;
`else
    step_hold = 1'b0;
`endif
    step = step_hold;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // 1. Reset during ISSUE drops everything
    iss_ready = 1'b0;
    push(OP_ADD, 4'd1, 4'd2);
    push(OP_OR, 4'd5, 4'd8);
    push(OP_EQ, 4'd3, 4'd3);
    wait_iss_valid();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("post_rst_idle", 32'(iss_valid), 0);

    // 2. Single op with exact latency
    iss_ready = 1'b1;
    push(OP_ADD, 4'd3, 4'd4);          // edge N
    check("lat_n", 32'(iss_valid), 0);
    tick();                            // N+1
    check("lat_n1", 32'(iss_valid), 0);
    tick();                            // N+2
    check("lat_n2_valid", 32'(iss_valid), 1);
    check("lat_n2_word", 32'({iss_sel, iss_rs, iss_rt}), 32'({OP_ADD, 4'd3, 4'd4}));
    tick();                            // N+3 capture
    check("single_rd", 32'(last_rd), 32'd7);
    check("single_cnt", 32'(issued_cnt), 32'd1);
    check("single_res_valid", 32'(res_valid), 1);
    tick();

    // 3. Backpressure
    iss_ready = 1'b0;
    push(OP_SUB, 4'd2, 4'd5);
    wait_iss_valid();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", 32'(iss_valid), 1);
      check("bp_hold_word", 32'({iss_sel, iss_rs, iss_rt}), 32'({OP_SUB, 4'd2, 4'd5}));
    end
    iss_ready = 1'b1;
    tick();
    check("bp_rd", 32'(last_rd), 32'hD);
    check("bp_cnt", 32'(issued_cnt), 32'd2);
    tick();

    // 4. Full queue: 5 back-to-back pushes, 1 moves to ISSUE, 4 fill the queue
    iss_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(3'(i + 2), 4'(i + 1), 4'(2 * i));
    check("full_in_ready", 32'(in_ready), 0);
    in_valid = 1'b1; in_sel = OP_LT; in_rs = 4'd1; in_rt = 4'd9;
    tick();
    tick();
    check("full_hold_ready", 32'(in_ready), 0);
    in_valid = 1'b0;
    drain();
    check("full_cnt", 32'(issued_cnt), 32'd7);

    // 5. Counter and pointer wrap with random traffic
    rst = 1'b1;
    tick();
    rst = 1'b0;
    npush = 0;
    n = 0;
    while (npush < 257 && n < 4000) begin
      in_valid = 1'b1;
      in_sel = 3'($urandom_range(0, 7));
      in_rs = 4'($urandom_range(0, 15));
      in_rt = 4'($urandom_range(0, 15));
      iss_ready = 1'($urandom_range(0, 1));
      if (in_ready) npush++;
      tick();
      n++;
    end
    in_valid = 1'b0;
    check("wrap_pushes", 32'(npush), 32'd257);
    drain();
    check("wrap_cnt", 32'(issued_cnt), 32'd1);

    // 6. Single-step
    step = 1'b0;
    iss_ready = 1'b1;
    tick();
    cnt0 = model_cnt;
    push(OP_AND, 4'd12, 4'd10);
    push(OP_LSH, 4'd3, 4'd1);
`ifdef INSTR_STEP_EN
    for (int i = 0; i < 8; i++) tick();
    check("step_wait", 32'(iss_valid), 0);
    check("step_none", 32'(model_cnt - cnt0), 0);
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("step_one", 32'(model_cnt - cnt0), 1);
    check("step_one_hw", 32'(issued_cnt), 32'(2));
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("step_two", 32'(model_cnt - cnt0), 2);
    check("step_queue", 32'(exp_q.size()), 0);
`else
    for (int i = 0; i < 16; i++) tick();
    check("nostep_two", 32'(model_cnt - cnt0), 2);
    check("nostep_queue", 32'(exp_q.size()), 0);
`endif
    check("final_rd", 32'(last_rd), 32'(4'd6));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
